// File: rtl/line_window_3x3_reader.sv
// Reading end of a two-row line buffer: sequences two cascaded row FIFOs and forms a registered 3x3 window.
// Optional FIFO protocol checking is built when LINE_WIN_ERR_CHECK_EN is defined; otherwise o_err is tied low.

module line_window_col_shift #(
  parameter int DW = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shift,
  input  logic [DW-1:0]      tap,
  output logic [2:0][DW-1:0] taps
);
  // New pixel enters at the right (index 2); older columns move left.
  always_ff @(posedge clk) begin
    if (rst)        taps <= '0;
    else if (shift) taps <= {tap, taps[2], taps[1]};
  end
endmodule

module line_window_3x3_reader #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_IMG_WIDTH  = 640,
  parameter int P_IMG_HEIGHT = 512
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_pix_valid,
  input  logic [P_DATA_WIDTH-1:0]   i_pix_data,
  output logic                      o_wr_en1,
  output logic [P_DATA_WIDTH-1:0]   o_din1,
  output logic                      o_rd_en1,
  input  logic [P_DATA_WIDTH-1:0]   i_dout1,
  input  logic                      i_empty1,
  input  logic                      i_full1,
  output logic                      o_wr_en2,
  output logic [P_DATA_WIDTH-1:0]   o_din2,
  output logic                      o_rd_en2,
  input  logic [P_DATA_WIDTH-1:0]   i_dout2,
  input  logic                      i_empty2,
  input  logic                      i_full2,
  output logic                      o_win_valid,
  output logic [9*P_DATA_WIDTH-1:0] o_window,
  output logic                      o_frame_done,
  output logic                      o_err
);
  localparam int DW = P_DATA_WIDTH;
  localparam int CW = (P_IMG_WIDTH  > 1) ? $clog2(P_IMG_WIDTH)  : 1;
  localparam int RW = (P_IMG_HEIGHT > 1) ? $clog2(P_IMG_HEIGHT) : 1;

  typedef enum logic [1:0] {FILL0, FILL1, STREAM, LAST} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic            acc, col_last, row_last, emit;
  logic [DW-1:0]   tap [3];
  logic [2:0][DW-1:0] row_q [3];

  assign acc      = i_pix_valid;
  assign col_last = (col == CW'(P_IMG_WIDTH - 1));
  assign row_last = (row == RW'(P_IMG_HEIGHT - 1));
  assign emit     = acc && (row >= RW'(2)) && (col >= CW'(2));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= FILL0;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_nxt;
      if (acc) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  // Strobes are same-cycle with the pixel; FIFO heads are consumed combinationally.
  always_comb begin
    state_nxt = state;
    o_wr_en1  = 1'b0;
    o_rd_en1  = 1'b0;
    o_wr_en2  = 1'b0;
    o_rd_en2  = 1'b0;
    o_din1    = '0;
    o_din2    = '0;
    tap[0]    = '0;
    tap[1]    = '0;
    tap[2]    = i_pix_data;
    case (state)
      FILL0: begin
        o_wr_en1 = acc;
        o_din1   = acc ? i_pix_data : '0;
        if (acc && col_last) state_nxt = FILL1;
      end
      FILL1: begin
        o_rd_en1 = acc;
        o_wr_en2 = acc;
        o_din2   = acc ? i_dout1 : '0;
        o_wr_en1 = acc;
        o_din1   = acc ? i_pix_data : '0;
        tap[1]   = i_dout1;
        if (acc && col_last) state_nxt = (P_IMG_HEIGHT == 3) ? LAST : STREAM;
      end
      STREAM: begin
        o_rd_en1 = acc;
        o_rd_en2 = acc;
        o_wr_en2 = acc;
        o_din2   = acc ? i_dout1 : '0;
        o_wr_en1 = acc;
        o_din1   = acc ? i_pix_data : '0;
        tap[0]   = i_dout2;
        tap[1]   = i_dout1;
        if (acc && col_last && (row == RW'(P_IMG_HEIGHT - 2))) state_nxt = LAST;
      end
      LAST: begin
        o_rd_en1 = acc;
        o_rd_en2 = acc;
        tap[0]   = i_dout2;
        tap[1]   = i_dout1;
        if (acc && col_last) state_nxt = FILL0;
      end
      default: state_nxt = FILL0;
    endcase
  end

  genvar r;
  generate
    for (r = 0; r < 3; r++) begin : g_row
      line_window_col_shift #(.DW(DW)) u_shift (
        .clk   (i_clk),
        .rst   (i_rst),
        .shift (acc),
        .tap   (tap[r]),
        .taps  (row_q[r])
      );
      assign o_window[r*3*DW +: 3*DW] = row_q[r];
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_win_valid  <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_win_valid  <= emit;
      o_frame_done <= acc && (state == LAST) && col_last;
    end
  end

`ifdef LINE_WIN_ERR_CHECK_EN
  logic err;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      err <= 1'b0;
    else if ((o_rd_en1 && i_empty1) || (o_rd_en2 && i_empty2) ||
             (o_wr_en1 && i_full1)  || (o_wr_en2 && i_full2))
      err <= 1'b1;
  end

  assign o_err = err;
`else
  logic unused_flags;

  assign unused_flags = i_empty1 ^ i_empty2 ^ i_full1 ^ i_full2;
  assign o_err        = 1'b0;
`endif

endmodule

// File: tb/tb_line_window_3x3_reader.sv
// Bench for line_window_3x3_reader: queue-based FIFO models, raster-position window model, strobe table.
module tb_line_window_3x3_reader;
  localparam int DW = 8, W = 4, H = 4, DEPTH = 8;

  logic clk = 1'b0, rst = 1'b0, pix_valid = 1'b0;
  logic [DW-1:0] pix_data = '0;
  logic wr1, rd1, wr2, rd2, win_valid, frame_done, err;
  logic [DW-1:0] din1, din2;
  logic [DW-1:0] dout1 = '0, dout2 = '0;
  logic emp1_m = 1'b1, emp2_m = 1'b1, full1 = 1'b0, full2 = 1'b0;
  logic inj_empty1 = 1'b0;
  logic empty1, empty2;
  logic [9*DW-1:0] window;

  assign empty1 = emp1_m | inj_empty1;
  assign empty2 = emp2_m;

  always #5 clk = ~clk;

  line_window_3x3_reader #(.P_DATA_WIDTH(DW), .P_IMG_WIDTH(W), .P_IMG_HEIGHT(H)) dut (
    .i_clk(clk), .i_rst(rst), .i_pix_valid(pix_valid), .i_pix_data(pix_data),
    .o_wr_en1(wr1), .o_din1(din1), .o_rd_en1(rd1),
    .i_dout1(dout1), .i_empty1(empty1), .i_full1(full1),
    .o_wr_en2(wr2), .o_din2(din2), .o_rd_en2(rd2),
    .i_dout2(dout2), .i_empty2(empty2), .i_full2(full2),
    .o_win_valid(win_valid), .o_window(window),
    .o_frame_done(frame_done), .o_err(err)
  );

  // Read-latency-0 FIFO models
  logic [DW-1:0] q1[$], q2[$];
  always @(posedge clk) begin
    if (rst) begin
      q1.delete(); q2.delete();
    end else begin
      if (rd1 && q1.size() > 0) void'(q1.pop_front());
      if (wr1) q1.push_back(din1);
      if (rd2 && q2.size() > 0) void'(q2.pop_front());
      if (wr2) q2.push_back(din2);
    end
    dout1  <= (q1.size() > 0) ? q1[0] : '0;
    dout2  <= (q2.size() > 0) ? q2[0] : '0;
    emp1_m <= (q1.size() == 0);
    emp2_m <= (q2.size() == 0);
    full1  <= (q1.size() >= DEPTH);
    full2  <= (q2.size() >= DEPTH);
  end

  int n_chk = 0, n_fail = 0;
  int k = 0, nwin = 0, nfd = 0, consec = 0;
  logic [DW-1:0] img [H][W];
  logic exp_wv = 1'b0, exp_fd = 1'b0, exp_err = 1'b0, prev_wv = 1'b0, cap_first = 1'b0;
  logic [9*DW-1:0] exp_win = '0, first_win = '0;

  task automatic chk(input string name, input logic [9*DW-1:0] act, input logic [9*DW-1:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Drive one input cycle and compute the expected registered outputs from raster position.
  task automatic apply(input logic v, input logic [DW-1:0] d);
    int r, c;
    pix_valid = v;
    pix_data  = d;
    exp_wv = 1'b0;
    exp_fd = 1'b0;
    if (v) begin
      r = k / W;
      c = k % W;
      img[r][c] = d;
      exp_fd = (k == W*H - 1);
      if (r >= 2 && c >= 2) begin
        exp_wv = 1'b1;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            exp_win[(3*i+j)*DW +: DW] = img[r-2+i][c-2+j];
      end
      k = (k + 1) % (W*H);
    end
    #1;
  endtask

  task automatic clock_and_check();
    @(posedge clk);
    #1;
    chk("win_valid", win_valid, exp_wv);
    if (exp_wv) begin
      chk("window", window, exp_win);
      if (cap_first) begin first_win = window; cap_first = 1'b0; end
    end
    if (win_valid) nwin++;
    if (win_valid && prev_wv) consec++;
    prev_wv = win_valid;
    chk("frame_done", frame_done, exp_fd);
    if (frame_done) nfd++;
    chk("err", err, exp_err);
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d);
    apply(v, d);
    clock_and_check();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pix_valid = 1'b0;
    pix_data = '0;
    @(posedge clk);
    #1;
    chk("rst_win_valid", win_valid, 0);
    chk("rst_window", window, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    k = 0;
    exp_err = 1'b0;
    prev_wv = 1'b0;
  endtask

  task automatic frame(input logic [DW-1:0] base, input bit gapped);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        step(1'b1, base + DW'(r*16 + c));
        if (gapped) step(1'b0, '0);
      end
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic wr1, rd1, wr2, rd2;
    logic [DW-1:0] din2;
  } vec_t;
  vec_t tbl [W*H];

  localparam logic [9*DW-1:0] WIN_FIRST  = 72'h22_21_20_12_11_10_02_01_00;
  localparam logic [9*DW-1:0] WIN_FIRST2 = 72'hA2_A1_A0_92_91_90_82_81_80;

  initial begin
    // Expected strobes per raster position: row 0 fill, row 1 cascade, middle rows stream, last row drain.
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        tbl[r*W+c].d    = DW'(r*16 + c);
        tbl[r*W+c].wr1  = (r < H-1);
        tbl[r*W+c].rd1  = (r >= 1);
        tbl[r*W+c].wr2  = (r >= 1) && (r < H-1);
        tbl[r*W+c].rd2  = (r >= 2);
        tbl[r*W+c].din2 = DW'((r-1)*16 + c);
      end

    do_reset();

    // Scenario 1: continuous frame, table-driven strobe checks
    nwin = 0; nfd = 0; cap_first = 1'b1;
    for (int i = 0; i < W*H; i++) begin
      apply(1'b1, tbl[i].d);
      chk("wr_en1", wr1, tbl[i].wr1);
      chk("rd_en1", rd1, tbl[i].rd1);
      chk("wr_en2", wr2, tbl[i].wr2);
      chk("rd_en2", rd2, tbl[i].rd2);
      if (tbl[i].wr1) chk("din1", din1, tbl[i].d);
      if (tbl[i].wr2) chk("din2", din2, tbl[i].din2);
      clock_and_check();
    end
    chk("s1_first_window", first_win, WIN_FIRST);
    chk("s1_last_p22", window[8*DW +: DW], 8'h33);
    chk("s1_win_count", nwin, (W-2)*(H-2));
    chk("s1_fd_count", nfd, 1);
    step(1'b0, '0);
    chk("s1_fd_gone", frame_done, 0);
    chk("s1_fifo1_empty", emp1_m, 1);
    chk("s1_fifo2_empty", emp2_m, 1);

    // Scenario 2: gapped frame, then back-to-back offset frame
    nwin = 0; consec = 0; cap_first = 1'b1;
    frame(8'h00, 1'b1);
    chk("s2_first_window", first_win, WIN_FIRST);
    chk("s2_win_count", nwin, (W-2)*(H-2));
    chk("s2_no_consecutive", consec, 0);
    nwin = 0; cap_first = 1'b1;
    frame(8'h80, 1'b0);
    chk("s3_first_window", first_win, WIN_FIRST2);
    chk("s3_win_count", nwin, (W-2)*(H-2));

    // Scenario 4: reset after pixel 0x21, then a clean frame
    for (int i = 0; i < 2*W + 2; i++) step(1'b1, tbl[i].d);
    do_reset();
    step(1'b0, '0);
    chk("s4_fifo1_empty", emp1_m, 1);
    chk("s4_fifo2_empty", emp2_m, 1);
    nwin = 0; nfd = 0; cap_first = 1'b1;
    frame(8'h00, 1'b0);
    chk("s4_first_window", first_win, WIN_FIRST);
    chk("s4_win_count", nwin, (W-2)*(H-2));
    chk("s4_fd_count", nfd, 1);

    // Scenario 5: random data and gaps over two frames against the raster model
    nwin = 0;
    for (int n = 0, acc = 0; n < 2000 && acc < 2*W*H; n++) begin
      logic v;
      v = ($urandom_range(0, 2) != 0);
      step(v, DW'($urandom));
      if (v) acc++;
    end
    chk("s5_win_count", nwin, 2*(W-2)*(H-2));
    chk("s5_fifo1_empty", emp1_m, 1);

    // Scenario 6: spurious empty1 during row 2 pop
    for (int i = 0; i < 2*W + 1; i++) step(1'b1, tbl[i].d);
    inj_empty1 = 1'b1;
    apply(1'b1, tbl[2*W + 1].d);
`ifdef LINE_WIN_ERR_CHECK_EN
    exp_err = 1'b1;
`endif
    clock_and_check();
    inj_empty1 = 1'b0;
    for (int i = 2*W + 2; i < W*H; i++) step(1'b1, tbl[i].d);
    for (int i = 0; i < 3; i++) step(1'b0, '0);
    do_reset();
    step(1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
